// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: stall/flush scheduler for the five-stage in-order pipeline.
// It combines stage back-pressure, EXE branch redirects, WB traps and
// serializing instructions into per-stage stall and flush controls. It also
// owns the pending fetch-redirect request.
// Optional build macro: PIPE_PERF_CNT_EN enables the 64-bit stall-cycle and
// flush-event counters. Without it both perf outputs are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow, no serializing instruction outstanding
// DRAIN    | serializing instr held in ID until EXE/MEM/WB are empty
// INFLIGHT | serializing instr issued; younger ID instr held until it
//          | retires in WB
module pipe_hazard_sched #(
  parameter int PC_W = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic            id_valid,
  input  logic            exe_valid,
  input  logic            mem_valid,
  input  logic            wb_valid,
  input  logic            exe_ready,
  input  logic            mem_ready,
  input  logic            id_serialize,
  input  logic            br_redirect,
  input  logic [PC_W-1:0] br_target,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_target,
  input  logic            fetch_redirect_ready,
  output logic            if_stall,
  output logic            id_stall,
  output logic            exe_stall,
  output logic            mem_stall,
  output logic            if_flush,
  output logic            id_flush,
  output logic            exe_flush,
  output logic            mem_flush,
  output logic            fetch_redirect_valid,
  output logic [PC_W-1:0] fetch_redirect_pc,
  output logic [63:0]     perf_stall_cycles,
  output logic [63:0]     perf_flush_events
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_INFLIGHT = 2'd2
  } state_t;

  state_t          state_q, state_nxt;
  logic [1:0]      pos_q, pos_nxt;
  logic            pend_valid_q;
  logic [PC_W-1:0] pend_pc_q;

  logic            mem_stall_c, exe_stall_c, id_stall_c, if_stall_c;
  logic            exe_fire, trap_take, br_accept, front_flush;
  logic            serial_hold, pipe_busy;
  logic            exe_flush_c, mem_flush_c;

  // IF is not consumed here; the stall chain starts at ID.
  logic            unused_ok;
  assign unused_ok = if_valid;

  // Back-pressure chain, fire conditions, redirect/trap acceptance.
  always_comb begin
    mem_stall_c = mem_valid & ~mem_ready;
    exe_stall_c = mem_stall_c | (exe_valid & ~exe_ready);
    id_stall_c  = exe_stall_c | serial_hold;
    if_stall_c  = id_stall_c | pend_valid_q;
    exe_fire    = exe_valid & ~exe_stall_c;
    trap_take   = wb_valid & trap_valid;
    br_accept   = exe_fire & br_redirect & ~trap_take;
    front_flush = br_accept | trap_take;
    exe_flush_c = (id_stall_c & ~exe_stall_c) | trap_take;
    mem_flush_c = (exe_stall_c & ~mem_stall_c) | trap_take;
    pipe_busy   = exe_valid | mem_valid | wb_valid;
  end

  // While in reset: flush everything, stall nothing, no redirect visible.
  always_comb begin
    mem_stall            = ~rst & mem_stall_c;
    exe_stall            = ~rst & exe_stall_c;
    id_stall             = ~rst & id_stall_c;
    if_stall             = ~rst & if_stall_c;
    if_flush             = rst | front_flush;
    id_flush             = rst | front_flush;
    exe_flush            = rst | exe_flush_c;
    mem_flush            = rst | mem_flush_c;
    fetch_redirect_valid = ~rst & pend_valid_q;
    fetch_redirect_pc    = rst ? '0 : pend_pc_q;
  end

  // Serialization FSM next-state and ID hold.
  always_comb begin
    state_nxt   = state_q;
    pos_nxt     = pos_q;
    serial_hold = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (id_valid && id_serialize) begin
          if (pipe_busy) begin
            serial_hold = 1'b1;
            state_nxt   = ST_DRAIN;
          end else if (!exe_stall_c) begin
            state_nxt = ST_INFLIGHT;
            pos_nxt   = 2'd0;
          end else begin
            serial_hold = 1'b1;
          end
        end
        // The serializing instr in ID was flushed; nothing to track.
        if (front_flush) state_nxt = ST_RUN;
      end
      ST_DRAIN: begin
        if (pipe_busy) begin
          serial_hold = 1'b1;
        end else begin
          state_nxt = id_valid ? ST_INFLIGHT : ST_RUN;
          pos_nxt   = 2'd0;
        end
        if (front_flush) state_nxt = ST_RUN;
      end
      ST_INFLIGHT: begin
        serial_hold = id_valid;
        // pos: 0 = serialized instr in EXE, 1 = MEM, 2 = WB
        if (pos_q == 2'd2 && wb_valid) begin
          state_nxt = ST_RUN;
        end else if ((pos_q == 2'd0 && exe_fire) ||
                     (pos_q == 2'd1 && mem_valid && !mem_stall_c)) begin
          pos_nxt = pos_q + 2'd1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (trap_take) state_nxt = ST_RUN;
  end

  // FSM state and position counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pos_q   <= 2'd0;
    end else begin
      state_q <= state_nxt;
      pos_q   <= pos_nxt;
    end
  end

  // Pending redirect: trap beats branch, any load beats a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
    end else if (trap_take) begin
      pend_valid_q <= 1'b1;
      pend_pc_q    <= trap_target;
    end else if (br_accept) begin
      pend_valid_q <= 1'b1;
      pend_pc_q    <= br_target;
    end else if (fetch_redirect_ready) begin
      pend_valid_q <= 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [63:0] stall_cnt_q, flush_cnt_q;

  // Wrap-around counters of held-ID cycles and front-end redirect events.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (id_stall_c && id_valid) stall_cnt_q <= stall_cnt_q + 64'd1;
      if (front_flush)            flush_cnt_q <= flush_cnt_q + 64'd1;
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_flush_events = flush_cnt_q;
`else
  assign perf_stall_cycles = 64'd0;
  assign perf_flush_events = 64'd0;
`endif

endmodule
